// File: rtl/axi3_rd_if.sv
// AXI3 read-channel bundle (AR + R) shared by the cache masters and the external port.
// ID_W sets the ARID/RID width; data is fixed at 32 bits.
interface axi3_rd_if #(
  parameter int ID_W = 4
) ();
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            rvalid;
  logic            rready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi3_rd_arbiter.sv
// Three-to-one AXI3 read arbiter: round-robin AR grant through a one-entry stage,
// RID-based R return, and a per-master cap on outstanding bursts.
module axi3_rd_arbiter #(
  parameter int BUS_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       rst,
  axi3_rd_if.slave   s0,
  axi3_rd_if.slave   s1,
  axi3_rd_if.slave   s2,
  axi3_rd_if.master  m,
  output logic       err_rid
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

  state_t               state_r;
  logic [1:0]           last_grant_r;
  logic                 arvalid_r;
  logic [BUS_WIDTH-1:0] arid_r;
  logic [31:0]          araddr_r;
  logic [3:0]           arlen_r;
  logic [2:0]           arsize_r;
  logic [1:0]           arburst_r;
  logic [1:0]           arlock_r;
  logic [3:0]           arcache_r;
  logic [2:0]           arprot_r;
  logic [CW-1:0]        cnt_r [3];
  logic                 err_rid_r;

  logic [2:0]  req_s, elig_s, ar_hs_s, rvalid_s, r_done_s;
  logic [1:0]  win_s, rid_lo_s;
  logic        win_vld_s, grant_s, rid_ok_s, rready_s;
  logic [31:0] sel_addr_s;
  logic [3:0]  sel_len_s, sel_cache_s;
  logic [2:0]  sel_size_s, sel_prot_s;
  logic [1:0]  sel_burst_s, sel_lock_s;

  // (base + step) mod 3 for base in 0..2, step in 1..3
  function automatic logic [1:0] rr_next(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 3'd6) begin
      rr_next = 2'(sum - 3'd6);
    end else if (sum >= 3'd3) begin
      rr_next = 2'(sum - 3'd3);
    end else begin
      rr_next = sum[1:0];
    end
  endfunction

  assign req_s = {s2.arvalid, s1.arvalid, s0.arvalid};

  // Eligibility and round-robin winner; the k=1 candidate is evaluated last so it wins.
  always_comb begin
    elig_s    = 3'b000;
    win_s     = 2'd0;
    win_vld_s = 1'b0;
    for (int i = 0; i < 3; i++) begin
      elig_s[i] = req_s[i] && (cnt_r[i] != CNT_MAX);
    end
    for (int k = 3; k >= 1; k--) begin
      if (elig_s[rr_next(last_grant_r, 2'(k))]) begin
        win_s     = rr_next(last_grant_r, 2'(k));
        win_vld_s = 1'b1;
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  assign grant_s = (state_r == ST_IDLE) && win_vld_s;

  // One-hot AR handshake per master
  always_comb begin
    ar_hs_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      ar_hs_s[i] = grant_s && (win_s == 2'(i));
    end
  end

  assign s0.arready = ar_hs_s[0];
  assign s1.arready = ar_hs_s[1];
  assign s2.arready = ar_hs_s[2];

  // AR field mux of the winning master
  always_comb begin
    case (win_s)
      2'd0: begin
        sel_addr_s = s0.araddr;  sel_len_s  = s0.arlen;  sel_size_s  = s0.arsize;
        sel_burst_s = s0.arburst; sel_lock_s = s0.arlock; sel_cache_s = s0.arcache;
        sel_prot_s = s0.arprot;
      end
      2'd1: begin
        sel_addr_s = s1.araddr;  sel_len_s  = s1.arlen;  sel_size_s  = s1.arsize;
        sel_burst_s = s1.arburst; sel_lock_s = s1.arlock; sel_cache_s = s1.arcache;
        sel_prot_s = s1.arprot;
      end
      default: begin
        sel_addr_s = s2.araddr;  sel_len_s  = s2.arlen;  sel_size_s  = s2.arsize;
        sel_burst_s = s2.arburst; sel_lock_s = s2.arlock; sel_cache_s = s2.arcache;
        sel_prot_s = s2.arprot;
      end
    endcase
  end

  // AR state machine and registered downstream AR stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 2'd2;
      arvalid_r    <= 1'b0;
      arid_r       <= {BUS_WIDTH{1'b0}};
      araddr_r     <= 32'h0;
      arlen_r      <= 4'h0;
      arsize_r     <= 3'h0;
      arburst_r    <= 2'h0;
      arlock_r     <= 2'h0;
      arcache_r    <= 4'h0;
      arprot_r     <= 3'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_vld_s) begin
            state_r      <= ST_ISSUE;
            last_grant_r <= win_s;
            arvalid_r    <= 1'b1;
            arid_r       <= BUS_WIDTH'(win_s);
            araddr_r     <= sel_addr_s;
            arlen_r      <= sel_len_s;
            arsize_r     <= sel_size_s;
            arburst_r    <= sel_burst_s;
            arlock_r     <= sel_lock_s;
            arcache_r    <= sel_cache_s;
            arprot_r     <= sel_prot_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (m.arready) begin
            state_r   <= ST_IDLE;
            arvalid_r <= 1'b0;
          end else begin
            state_r <= ST_ISSUE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          arvalid_r <= 1'b0;
        end
      endcase
    end
  end

  assign m.arvalid = arvalid_r;
  assign m.arid    = arid_r;
  assign m.araddr  = araddr_r;
  assign m.arlen   = arlen_r;
  assign m.arsize  = arsize_r;
  assign m.arburst = arburst_r;
  assign m.arlock  = arlock_r;
  assign m.arcache = arcache_r;
  assign m.arprot  = arprot_r;

  assign rid_lo_s = m.rid[1:0];
  assign rid_ok_s = ((m.rid >> 2) == {BUS_WIDTH{1'b0}}) && (rid_lo_s != 2'd3);

  // R demux; unknown RIDs are sunk so the shared channel never locks up
  always_comb begin
    rvalid_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      rvalid_s[i] = m.rvalid && rid_ok_s && (rid_lo_s == 2'(i));
    end
    if (!rid_ok_s) begin
      rready_s = 1'b1;
    end else begin
      case (rid_lo_s)
        2'd0:    rready_s = s0.rready;
        2'd1:    rready_s = s1.rready;
        default: rready_s = s2.rready;
      endcase
    end
    r_done_s = rvalid_s & {3{rready_s & m.rlast}};
  end

  assign m.rready  = rready_s;
  assign s0.rvalid = rvalid_s[0];
  assign s1.rvalid = rvalid_s[1];
  assign s2.rvalid = rvalid_s[2];
  assign s0.rdata  = m.rdata;
  assign s1.rdata  = m.rdata;
  assign s2.rdata  = m.rdata;
  assign s0.rresp  = m.rresp;
  assign s1.rresp  = m.rresp;
  assign s2.rresp  = m.rresp;
  assign s0.rlast  = m.rlast;
  assign s1.rlast  = m.rlast;
  assign s2.rlast  = m.rlast;
  assign s0.rid    = m.rid;
  assign s1.rid    = m.rid;
  assign s2.rid    = m.rid;

  // Outstanding-burst counters; a completion with nothing outstanding is ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= {CW{1'b0}};
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        case ({ar_hs_s[i], r_done_s[i]})
          2'b10: cnt_r[i] <= cnt_r[i] + CW'(1);
          2'b01: begin
            if (cnt_r[i] != {CW{1'b0}}) begin
              cnt_r[i] <= cnt_r[i] - CW'(1);
            end else begin
              cnt_r[i] <= cnt_r[i];
            end
          end
          default: cnt_r[i] <= cnt_r[i];
        endcase
      end
    end
  end

  // Sticky flag for R beats carrying an RID no master owns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_rid_r <= 1'b0;
    end else if (m.rvalid && !rid_ok_s) begin
      err_rid_r <= 1'b1;
    end else begin
      err_rid_r <= err_rid_r;
    end
  end

  assign err_rid = err_rid_r;

endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// Scoreboard bench for axi3_rd_arbiter: directed AR/R traffic, expected downstream AR
// and upstream R beats queued at stimulus time and checked by an independent monitor.
module tb_axi3_rd_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err_rid;

  always #5 clk = ~clk;

  axi3_rd_if #(.ID_W(4)) s0_if ();
  axi3_rd_if #(.ID_W(4)) s1_if ();
  axi3_rd_if #(.ID_W(4)) s2_if ();
  axi3_rd_if #(.ID_W(4)) m_if ();

  axi3_rd_arbiter #(.BUS_WIDTH(4), .MAX_OUTSTANDING(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .s0      (s0_if),
    .s1      (s1_if),
    .s2      (s2_if),
    .m       (m_if),
    .err_rid (err_rid)
  );

  typedef struct packed {logic [3:0] id; logic [31:0] addr;} ar_exp_t;
  typedef struct packed {logic [1:0] idx; logic [31:0] data;} r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  int n_vec = 0;
  int n_err = 0;
  int ar_hs_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an AR or R handshake
  ar_exp_t mon_ar;
  r_exp_t  mon_r;
  logic [2:0]  mon_rv;
  logic [31:0] mon_d;
  always @(negedge clk) begin
    if (rst) begin
      if (m_if.arvalid && m_if.arready) begin
        ar_hs_cnt++;
        check("ar_expected", 64'(ar_q.size() != 0), 64'd1);
        if (ar_q.size() != 0) begin
          mon_ar = ar_q.pop_front();
          check("m_arid", 64'(m_if.arid), 64'(mon_ar.id));
          check("m_araddr", 64'(m_if.araddr), 64'(mon_ar.addr));
        end
      end
      mon_rv = {s2_if.rvalid, s1_if.rvalid, s0_if.rvalid};
      if (mon_rv != 3'b000) begin
        check("r_expected", 64'(r_q.size() != 0), 64'd1);
        if (r_q.size() != 0) begin
          mon_r = r_q.pop_front();
          check("s_rvalid_onehot", 64'(mon_rv), 64'(3'b001 << mon_r.idx));
          case (mon_r.idx)
            2'd0:    mon_d = s0_if.rdata;
            2'd1:    mon_d = s1_if.rdata;
            default: mon_d = s2_if.rdata;
          endcase
          check("s_rdata", 64'(mon_d), 64'(mon_r.data));
        end
      end
    end
  end

  // Caller is at posedge+1; returns at the following posedge+1 with R idle
  task automatic send_r(input logic [3:0] rid, input logic [31:0] data, input logic last);
    m_if.rvalid = 1'b1;
    m_if.rid    = rid;
    m_if.rdata  = data;
    m_if.rlast  = last;
    @(negedge clk);
    @(posedge clk); #1;
    m_if.rvalid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int grants;
    int hs0;
    s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0; s2_if.arvalid = 1'b0;
    s0_if.arid = 4'd0; s1_if.arid = 4'd0; s2_if.arid = 4'd0;
    s0_if.araddr = 32'h0; s1_if.araddr = 32'h0; s2_if.araddr = 32'h0;
    s0_if.arlen = 4'd0; s1_if.arlen = 4'd0; s2_if.arlen = 4'd0;
    s0_if.arsize = 3'd2; s1_if.arsize = 3'd2; s2_if.arsize = 3'd2;
    s0_if.arburst = 2'd1; s1_if.arburst = 2'd1; s2_if.arburst = 2'd1;
    s0_if.arlock = 2'd0; s1_if.arlock = 2'd0; s2_if.arlock = 2'd0;
    s0_if.arcache = 4'd0; s1_if.arcache = 4'd0; s2_if.arcache = 4'd0;
    s0_if.arprot = 3'd0; s1_if.arprot = 3'd0; s2_if.arprot = 3'd0;
    s0_if.rready = 1'b1; s1_if.rready = 1'b1; s2_if.rready = 1'b1;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rid = 4'd0;
    m_if.rdata = 32'h0; m_if.rresp = 2'd0; m_if.rlast = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_m_arvalid", 64'(m_if.arvalid), 64'd0);
    check("rst_arready", 64'({s2_if.arready, s1_if.arready, s0_if.arready}), 64'd0);
    check("rst_err_rid", 64'(err_rid), 64'd0);
    check("rst_m_rready", 64'(m_if.rready), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    tick();

    // Single read from master 2; its own arid is replaced by the index
    s2_if.arvalid = 1'b1; s2_if.araddr = 32'h1000; s2_if.arlen = 4'd0; s2_if.arid = 4'd7;
    @(negedge clk);
    check("single_s2_arready", 64'(s2_if.arready), 64'd1);
    check("single_s0_arready", 64'(s0_if.arready), 64'd0);
    ar_q.push_back('{id: 4'd2, addr: 32'h1000});
    tick();
    s2_if.arvalid = 1'b0;
    @(negedge clk);
    check("single_m_arvalid", 64'(m_if.arvalid), 64'd1);
    check("single_cnt2_up", 64'(dut.cnt_r[2]), 64'd1);
    tick();
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    r_q.push_back('{idx: 2'd2, data: 32'hDEADBEEF});
    send_r(4'd2, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("single_cnt2_down", 64'(dut.cnt_r[2]), 64'd0);
    tick();

    // Round robin with all three requesting; last grant was master 2
    s0_if.arvalid = 1'b1; s0_if.araddr = 32'h100;
    s1_if.arvalid = 1'b1; s1_if.araddr = 32'h200;
    s2_if.arvalid = 1'b1; s2_if.araddr = 32'h300;
    m_if.arready = 1'b1;
    ar_q.push_back('{id: 4'd0, addr: 32'h100});
    ar_q.push_back('{id: 4'd1, addr: 32'h200});
    ar_q.push_back('{id: 4'd2, addr: 32'h300});
    ar_q.push_back('{id: 4'd0, addr: 32'h100});
    hs0 = ar_hs_cnt;
    for (int c = 0; c < 20 && (ar_hs_cnt - hs0) < 4; c++) begin
      @(negedge clk); #1;
    end
    check("rr_hs_count", 64'(ar_hs_cnt - hs0), 64'd4);
    tick();
    s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0; s2_if.arvalid = 1'b0;
    m_if.arready = 1'b0;
    r_q.push_back('{idx: 2'd0, data: 32'hA0}); send_r(4'd0, 32'hA0, 1'b1);
    r_q.push_back('{idx: 2'd0, data: 32'hA1}); send_r(4'd0, 32'hA1, 1'b1);
    r_q.push_back('{idx: 2'd1, data: 32'hB0}); send_r(4'd1, 32'hB0, 1'b1);
    r_q.push_back('{idx: 2'd2, data: 32'hC0}); send_r(4'd2, 32'hC0, 1'b1);
    @(negedge clk);
    check("rr_cnt_drained", 64'({dut.cnt_r[2], dut.cnt_r[1], dut.cnt_r[0]}), 64'd0);
    tick();

    // Downstream backpressure holds the AR stage and blocks new grants
    s0_if.arvalid = 1'b1; s0_if.araddr = 32'h2000;
    @(negedge clk);
    check("bp_s0_arready", 64'(s0_if.arready), 64'd1);
    ar_q.push_back('{id: 4'd0, addr: 32'h2000});
    tick();
    s0_if.arvalid = 1'b0;
    s1_if.arvalid = 1'b1; s1_if.araddr = 32'h2100;
    repeat (5) begin
      @(negedge clk);
      check("bp_m_arvalid", 64'(m_if.arvalid), 64'd1);
      check("bp_m_araddr", 64'(m_if.araddr), 64'h2000);
      check("bp_s1_arready", 64'(s1_if.arready), 64'd0);
      tick();
    end
    m_if.arready = 1'b1;
    s1_if.arvalid = 1'b0;
    tick();
    m_if.arready = 1'b0;
    r_q.push_back('{idx: 2'd0, data: 32'h5555}); send_r(4'd0, 32'h5555, 1'b1);

    // Outstanding limit on master 1
    s1_if.arvalid = 1'b1; s1_if.araddr = 32'h3000;
    m_if.arready = 1'b1;
    repeat (4) ar_q.push_back('{id: 4'd1, addr: 32'h3000});
    grants = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (s1_if.arready) grants++;
      tick();
    end
    check("limit_grants", 64'(grants), 64'd4);
    check("limit_cnt1", 64'(dut.cnt_r[1]), 64'd4);
    r_q.push_back('{idx: 2'd1, data: 32'h11}); send_r(4'd1, 32'h11, 1'b1);
    @(negedge clk);
    check("limit_reopen", 64'(s1_if.arready), 64'd1);
    ar_q.push_back('{id: 4'd1, addr: 32'h3000});
    tick();
    s1_if.arvalid = 1'b0;
    tick();
    m_if.arready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      r_q.push_back('{idx: 2'd1, data: 32'(32'h20 + j)});
      send_r(4'd1, 32'(32'h20 + j), 1'b1);
    end
    @(negedge clk);
    check("limit_cnt1_drained", 64'(dut.cnt_r[1]), 64'd0);
    tick();

    // Bad RID is sunk, flagged, and cleared only by reset
    s0_if.rready = 1'b0; s1_if.rready = 1'b0; s2_if.rready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rid = 4'd3; m_if.rdata = 32'hBAD; m_if.rlast = 1'b1;
    @(negedge clk);
    check("badrid_m_rready", 64'(m_if.rready), 64'd1);
    check("badrid_no_rvalid", 64'({s2_if.rvalid, s1_if.rvalid, s0_if.rvalid}), 64'd0);
    tick();
    m_if.rvalid = 1'b0;
    s0_if.rready = 1'b1; s1_if.rready = 1'b1; s2_if.rready = 1'b1;
    @(negedge clk);
    check("badrid_err_set", 64'(err_rid), 64'd1);
    repeat (3) @(negedge clk);
    check("badrid_err_sticky", 64'(err_rid), 64'd1);
    @(posedge clk); #2 rst = 1'b0;
    #1 check("badrid_err_async_clr", 64'(err_rid), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // Reset in ST_ISSUE abandons the AR and restores master-0 priority
    s0_if.arvalid = 1'b1; s0_if.araddr = 32'h4000;
    tick();
    s0_if.arvalid = 1'b0;
    @(negedge clk);
    check("rmi_m_arvalid_pre", 64'(m_if.arvalid), 64'd1);
    #2 rst = 1'b0;
    #1 check("rmi_m_arvalid_async", 64'(m_if.arvalid), 64'd0);
    tick();
    rst = 1'b1;
    s0_if.arvalid = 1'b1; s0_if.araddr = 32'h100;
    s1_if.arvalid = 1'b1; s1_if.araddr = 32'h200;
    s2_if.arvalid = 1'b1; s2_if.araddr = 32'h300;
    m_if.arready = 1'b1;
    @(negedge clk);
    check("rmi_first_grant", 64'({s2_if.arready, s1_if.arready, s0_if.arready}), 64'b001);
    ar_q.push_back('{id: 4'd0, addr: 32'h100});
    tick();
    s0_if.arvalid = 1'b0; s1_if.arvalid = 1'b0; s2_if.arvalid = 1'b0;
    tick();
    m_if.arready = 1'b0;

    repeat (3) @(negedge clk);
    check("ar_queue_drained", 64'(ar_q.size()), 64'd0);
    check("r_queue_drained", 64'(r_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi3_rd_arbiter.md
# axi3_rd_arbiter

Three-to-one AXI3 read-channel arbiter between the cache-side read masters and the single external AXI3 read port. Master 0 is the icache, master 1 the dcache, master 2 dcache_pass. The arbiter grants AR requests round-robin through a registered one-entry stage and stamps ARID with the master index. It returns R beats to the requester by RID and bounds per-master outstanding reads.

## Interface
Parameters:
- BUS_WIDTH, 4, ID width of the axi3_rd_if instances; low 2 bits carry the master index.
- MAX_OUTSTANDING, 4, maximum accepted-but-not-completed read bursts per master (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- s0, s1, s2  axi3_rd_if.slave  interface  upstream masters 0/1/2.
- m  axi3_rd_if.master  interface  downstream AXI3 read port.
- err_rid  out  1  sticky flag; set when an R beat arrives with RID not in {0,1,2}.

## Operation
- State machine ST_IDLE / ST_ISSUE; reset state ST_IDLE.
- Round-robin pointer last_grant, 2 bits, reset value 2, so master 0 has top priority first.
- Eligibility: s[i].arvalid and cnt[i] != MAX_OUTSTANDING.
- ST_IDLE arbitration:
  - Winner is the first eligible master searching last_grant+1, +2, +3 modulo 3.
  - s[win].arready=1 combinationally in the same cycle; all other s.arready=0.
  - araddr/arlen/arsize/arburst/arlock/arcache/arprot are captured into ar_q.
  - arid_q is set to win (zero-extended to the ID width); the master's own arid is ignored.
  - last_grant is set to win; go to ST_ISSUE.
  - No eligible master: stay in ST_IDLE.
- ST_ISSUE:
  - m.arvalid=1 with ar_q fields, held stable until m.arready.
  - All s.arready=0.
  - On m.arready, go to ST_IDLE; no arbitration in that cycle.
- Outstanding counters cnt[0..2], width $clog2(MAX_OUTSTANDING+1), reset 0.
  - +1 on an s[i] AR handshake.
  - −1 on an R handshake with rlast and rid==i.
  - Both in the same cycle: counter unchanged.
  - Never underflows: an rlast for a master whose cnt is 0 leaves cnt at 0.
- R routing, fully combinational:
  - rdata/rresp/rlast/rid are broadcast to all s.
  - s[i].rvalid = m.rvalid & (rid[1:0]==i) & (rid upper bits==0).
  - m.rready = s[rid].rready.
  - RID outside 0..2: m.rready=1, beat dropped, err_rid set until reset.
- Reset (async assert, any time): state→ST_IDLE, m.arvalid→0, counters→0, last_grant→2, err_rid→0. An AR in flight is abandoned. The system resets the slave together with the arbiter.

## Timing
- Reset values: m.arvalid=0, all s.arready=0, err_rid=0. s.rvalid and m.rready follow their combinational equations.
- AR latency: s handshake in cycle T, m.arvalid asserted from T+1.
- Best-case AR throughput: one request per 2 cycles (IDLE→ISSUE→IDLE).
- R path has zero added latency. A master whose rready is low stalls the shared R channel; no reordering or buffering.
- A master's arvalid may drop before grant. Arbitration samples only the current cycle.

## Test plan
- Single read: s2 issues araddr=0x1000, arlen=0, arid=7. s2.arready is high in cycle T. m.arvalid is high at T+1 with arid=2, araddr=0x1000. Slave returns rid=2, rdata=0xDEADBEEF, rlast. Only s2.rvalid rises with 0xDEADBEEF; cnt[2] goes 1→0.
- Round robin: s0, s1, s2 all hold arvalid from reset. m sees arid sequence 0,1,2,0 across four AR handshakes, with m.arready tied high.
- Backpressure: m.arready low for 5 cycles in ST_ISSUE. m.arvalid and araddr remain stable. No s.arready asserts during the stall.
- Outstanding limit: s1 issues 5 reads, slave returns nothing. The first 4 are accepted; s1.arready stays low afterward. Returning one rlast with rid=1 allows the 5th to be accepted 1 cycle later, in ST_IDLE.
- Bad RID: slave sends rvalid, rid=3. m.rready=1, no s.rvalid, err_rid=1 and it stays high. Asserting rst low clears it asynchronously.
- Reset mid-issue: assert rst in ST_ISSUE. m.arvalid falls immediately. After release, the first grant goes to master 0 when all masters request.
